// File: rtl/key_encoder.sv
// Debounced 8-to-3 priority encoder for active-low request lines (line 7 highest).
// Each accepted press yields a registered code, a one-cycle strobe and a press count.
module key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic [7:0] in_n,
    input  logic       ei_n,
    output logic [2:0] code,
    output logic       strobe,
    output logic       gs_n,
    output logic [7:0] count,
    output logic       busy
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state;
    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [CW-1:0] cnt;
    logic [2:0]    cand;

    logic [7:0]    act;
    logic          any;
    logic [2:0]    winner;
    logic          accept;

    // Priority resolution on the synchronized lines; the highest index wins.
    always_comb begin
        act    = ~s2;
        any    = |act;
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
                winner = 3'(i);
            end
        end
    end

    // A press is accepted on the N-th consecutive sample of the same winner.
    always_comb begin
        accept = 1'b0;
        if (!ei_n && any) begin
            if (state == IDLE) begin
                accept = SINGLE;
            end else if (state == DEBOUNCE) begin
                accept = (winner == cand) && (cnt == LAST);
            end
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state  <= IDLE;
            s1     <= 8'hFF;
            s2     <= 8'hFF;
            cnt    <= '0;
            cand   <= 3'd0;
            code   <= 3'd0;
            strobe <= 1'b0;
            count  <= 8'd0;
            busy   <= 1'b0;
            gs_n   <= 1'b1;
        end else begin
            s1     <= in_n;
            s2     <= s1;
            gs_n   <= ~(any & ~ei_n);
            strobe <= 1'b0;

            if (accept) begin
                code   <= winner;
                strobe <= 1'b1;
                count  <= count + 8'd1;
                cand   <= winner;
                cnt    <= '0;
                state  <= HELD;
                busy   <= 1'b1;
            end else if (ei_n) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (any) begin
                            cand  <= winner;
                            cnt   <= CW'(1);
                            state <= DEBOUNCE;
                            busy  <= 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!any || winner != cand) begin
                            // Bounce or a different winner: restart from IDLE next cycle.
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (any) begin
                            cnt <= '0;
                        end else if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder: a reference model predicts strobes into a queue,
// a monitor pops and compares on every strobe and checks the level outputs each cycle.
module tb_key_encoder;

    localparam int N = 4;

    logic       hz100 = 1'b0;
    logic       reset;
    logic [7:0] in_n;
    logic       ei_n;
    logic [2:0] code;
    logic       strobe;
    logic       gs_n;
    logic [7:0] count;
    logic       busy;

    key_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .hz100  (hz100),
        .reset  (reset),
        .in_n   (in_n),
        .ei_n   (ei_n),
        .code   (code),
        .strobe (strobe),
        .gs_n   (gs_n),
        .count  (count),
        .busy   (busy)
    );

    always #5 hz100 = ~hz100;

    typedef struct {
        int         cyc;
        logic [2:0] code;
        logic [7:0] count;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int nstrobe = 0;

    // Reference model state
    bit         m_valid = 0;
    logic [7:0] m_p1, m_p2;
    int         m_mode;        // 0 waiting, 1 qualifying, 2 locked
    int         m_run;
    int         m_cand;
    logic [2:0] m_code;
    logic [7:0] m_count;
    logic       m_busy;
    logic       m_gs;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] hc138(input logic [2:0] a, input logic e1, input logic e2,
                                         input logic e3);
        logic [7:0] one;
        one = 8'd1;
        if (e1 || e2 || !e3) return 8'hFF;
        return ~(one << a);
    endfunction

    task automatic model_accept(input int line);
        exp_t e;
        m_code  = 3'(line);
        m_count = m_count + 8'd1;
        m_mode  = 2;
        m_run   = 0;
        e.cyc   = cyc;
        e.code  = m_code;
        e.count = m_count;
        q.push_back(e);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  win;
        bit  pressed;
        cyc++;
        if (reset) begin
            m_valid = 1;
            m_p1 = 8'hFF; m_p2 = 8'hFF;
            m_mode = 0; m_run = 0; m_cand = 0;
            m_code = 0; m_count = 0; m_busy = 0; m_gs = 1;
            return;
        end
        if (!m_valid) return;
        win = -1;
        for (int i = 0; i < 8; i++) if (!m_p2[i]) win = i;
        pressed = (win >= 0);
        m_gs = !(pressed && !ei_n);
        if (ei_n) begin
            m_mode = 0; m_run = 0;
        end else if (m_mode == 0) begin
            if (pressed) begin
                m_cand = win;
                if (N == 1) model_accept(win);
                else begin m_mode = 1; m_run = 1; end
            end
        end else if (m_mode == 1) begin
            if (!pressed || win != m_cand) m_mode = 0;
            else if (m_run == N - 1) model_accept(win);
            else m_run++;
        end else begin
            if (pressed) m_run = 0;
            else begin
                m_run++;
                if (m_run == N) begin m_mode = 0; m_run = 0; end
            end
        end
        m_busy = (m_mode != 0);
        m_p2 = m_p1;
        m_p1 = in_n;
    endtask

    // Monitor: level outputs every cycle, strobes against the scoreboard queue.
    always @(negedge hz100) begin
        if (m_valid) begin
            check("busy", int'(busy), int'(m_busy));
            check("gs_n", int'(gs_n), int'(m_gs));
            check("code", int'(code), int'(m_code));
            check("count", int'(count), int'(m_count));
            if (strobe === 1'b1) begin
                nstrobe++;
                if (q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_code", int'(code), int'(e.code));
                    check("strobe_count", int'(count), int'(e.count));
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                void'(q.pop_front());
                check("missing_strobe", 0, 1);
            end
        end
    end

    task automatic tick();
        @(posedge hz100);
        model_step();
        @(negedge hz100);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        in_n = v;
        repeat (n) tick();
    endtask

    int s;

    initial begin
        reset = 1'b1;
        ei_n  = 1'b0;
        in_n  = 8'h00;
        repeat (3) tick();
        check("rst_code", int'(code), 0);
        check("rst_strobe", int'(strobe), 0);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gs_n", int'(gs_n), 1);
        reset = 1'b0;
        hold(8'h00, 10);
        check("after_reset_code", int'(code), 7);
        hold(8'hFF, 8);

        s = nstrobe;
        hold(8'hFB, 12);
        check("single_strobes", nstrobe - s, 1);
        check("single_code", int'(code), 2);
        check("single_count", int'(count), 2);
        hold(8'hFF, 6);
        check("single_release_busy", int'(busy), 0);

        hold(8'hDD, 12);
        check("priority_code", int'(code), 5);
        hold(8'hFF, 8);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            logic [7:0] v;
            one = 8'd1;
            v = ~(one << i);
            hold(v, 10);
            check("loopback", int'(hc138(code, 1'b0, 1'b0, 1'b1)), int'(v));
            hold(8'hFF, 8);
        end

        s = nstrobe;
        hold(8'hF7, 2); hold(8'hFF, 1); hold(8'hF7, 3); hold(8'hFF, 1);
        check("bounce_rejected", nstrobe - s, 0);
        hold(8'hF7, 8);
        check("bounce_then_hold", nstrobe - s, 1);
        check("bounce_code", int'(code), 3);
        hold(8'hFF, 8);

        s = nstrobe;
        hold(8'hEF, 3);
        ei_n = 1'b1;
        tick();
        check("ei_abort_busy", int'(busy), 0);
        ei_n = 1'b0;
        hold(8'hFF, 8);
        check("ei_abort_strobes", nstrobe - s, 0);

        s = nstrobe;
        hold(8'hFE, 3);
        hold(8'hBE, 10);
        check("preempt_strobes", nstrobe - s, 1);
        check("preempt_code", int'(code), 6);
        hold(8'hFF, 8);

        hold(8'h7F, 8);
        s = nstrobe;
        in_n = 8'hFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("held_reset_count", int'(count), 0);
        check("held_reset_busy", int'(busy), 0);
        hold(8'hFF, 8);
        check("held_reset_strobes", nstrobe - s, 0);

        s = nstrobe;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] one;
            one = 8'd1;
            hold(~(one << $urandom_range(7, 0)), 7);
            hold(8'hFF, 7);
        end
        check("wrap_strobes", nstrobe - s, 256);
        check("wrap_count", int'(count), 0);

        hold(8'hFD, 8);
        s = nstrobe;
        hold(8'h7D, 10);
        hold(8'h7F, 10);
        check("lockout_strobes", nstrobe - s, 0);
        check("lockout_code", int'(code), 1);
        hold(8'hFF, 8);
        hold(8'h7F, 10);
        check("relock_strobes", nstrobe - s, 1);
        check("relock_code", int'(code), 7);
        hold(8'hFF, 8);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            logic [7:0] one;
            one = 8'd1;
            case ($urandom_range(3, 0))
                0: v = 8'hFF;
                1: v = ~(one << $urandom_range(7, 0));
                default: v = 8'($urandom);
            endcase
            ei_n  = ($urandom_range(15, 0) == 0);
            reset = ($urandom_range(63, 0) == 0);
            hold(v, $urandom_range(10, 1));
        end
        ei_n  = 1'b0;
        reset = 1'b0;
        hold(8'hFF, 12);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_encoder.md
# key_encoder

Debounced 8-to-3 priority encoder: the encoding counterpart to the board's 74HC138-style 3-to-8 active-low decoder. Eight active-low request lines (pushbuttons, or the active-low outputs of a decoder) pass through a 2-flop synchronizer and a press/release debounce FSM. The encoder also prioritises the lines as a 74HC148 does (line 7 highest). Each accepted press produces a registered 3-bit binary code, a one-cycle strobe and an incremented press count. The code is uninverted, so feeding it back into the decoder's address reproduces the one-hot of the winning line. The block sits in `top` between `pb[7:0]` and the display/state logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to accept a press or a release. Legal range ≥1.
- `hz100`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_n`  in  8  request lines, active-low, asynchronous to `hz100`.
- `ei_n`  in  1  enable input, active-low. When high, the block is forced idle.
- `code`  out  3  binary index of the last accepted line, registered.
- `strobe`  out  1  one-cycle pulse on each accepted press.
- `gs_n`  out  1  registered group select: low while the block is enabled and any synchronized line is active.
- `count`  out  8  number of accepted presses, wraps modulo 256.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- Synchronizer: `s1 <= in_n`, then `s2 <= s1`. Define `act = ~s2`. The winner is the highest set index of `act`; `any` is the OR of `act`.
- FSM states: IDLE, DEBOUNCE, HELD.
  - IDLE: if `any` and `ei_n` is low, set `cand` = winner, set `cnt` = 1, go to DEBOUNCE. If N = 1, accept immediately, exactly as in the DEBOUNCE accept case.
  - DEBOUNCE, when the winner is still `cand`:
    - If `cnt` = N−1, accept: `code <= cand`, `strobe <= 1`, `count <= count+1`, `cnt` = 0, go to HELD.
    - Otherwise `cnt++`.
  - DEBOUNCE, on `!any` or when the winner ≠ `cand`: go to IDLE with no strobe. The new winner is picked up on the following IDLE cycle.
  - HELD: new presses are ignored, including higher-priority ones.
    - While `!any`, `cnt++`. When the count reaches N consecutive released samples, go to IDLE.
    - Any `any` sample clears `cnt`.
- `ei_n` high in any state: go to IDLE next edge and clear `cnt`, with no strobe. `code` and `count` are retained.
- `strobe` is high for exactly one cycle per accepted press and never on two consecutive cycles.
- `gs_n <= ~(any & ~ei_n)` on every edge.
- `count` wraps from 255 to 0 with no flag.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Reset has priority over all other behaviour:
  - State goes to IDLE; `cnt` and `cand` are cleared.
  - `s1` and `s2` are set to 8'hFF.
  - `code` = 0, `strobe` = 0, `count` = 0, `busy` = 0, `gs_n` = 1.
  - Reset asserted mid-DEBOUNCE or mid-HELD produces no strobe.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Press latency: suppose `in_n` goes low before edge k and stays stable. Then `s1` updates at edge k, `s2` at k+1, and `act` is first observed at edge k+2. `strobe`, `code` and `count` update at edge k+1+N. `strobe` drops at edge k+2+N.
- `busy` rises at edge k+2.
- Release latency: suppose the line is released before edge r, with the FSM in HELD. Then `busy` falls at edge r+1+N. A new press can be observed from the following edge.
- `gs_n` follows `act` with 1 edge of delay, i.e. 2 edges after the `s1` capture.
- `ei_n` is not synchronized and is sampled directly. The integrator is responsible for synchronizing it if it is asynchronous.

## Test plan
- Reset: hold `in_n` = 8'h00 (all active) with `reset` = 1 for 3 cycles → `code` = 0, `strobe` = 0, `count` = 0, `busy` = 0, `gs_n` = 1. After release, the first strobe comes N+2 edges later.
- Single press, N = 4: `in_n` = 8'hFB (line 2) applied before edge k and held 12 cycles → `strobe` is high only between edges k+5 and k+6, `code` = 2, `count` = 1. Release before edge r → `busy` is 0 after edge r+5.
- Priority and loopback:
  - `in_n` = 8'hDD (lines 5 and 1) → `code` = 5.
  - Sweep each single line 0..7 and feed `code` into an hc138 with e1 = 0, e2 = 0, e3 = 1 → `y` equals `in_n` for every line.
- Bounce rejection: line 3 pattern active 2 / idle 1 / active 3 / idle 1 cycles → no strobe. Then hold active for 8 cycles → exactly one strobe, `code` = 3.
- Mid-operation aborts:
  - Line 4 held, with `ei_n` pulsed high during DEBOUNCE → no strobe and `busy` = 0 next edge; `count` is unchanged.
  - Line 0 pressed first, then line 6 during DEBOUNCE → a single strobe with `code` = 6.
  - `reset` pulsed during HELD → outputs return to reset values and no strobe occurs.
- Wrap and HELD lockout:
  - 256 clean presses → `count` returns to 0, with exactly 256 strobes.
  - While line 1 is in HELD, press line 7 → no strobe until all lines are released for N samples and line 7 is then re-accepted.
